// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch/decode types, halt encoding and instruction field positions
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [8:0] HALT_INSTR = 9'h1F0;
    localparam logic [2:0] OPC_BRANCH = 3'b100;
    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;
    localparam int IDX_HI = 3;
    localparam int IDX_LO = 0;
endpackage

// File: rtl/branch_lut.sv
// branch_lut: branch-target register file, one sync write port, one async read port
module branch_lut #(
    parameter int DEPTH = 16,
    parameter int W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) mem <= '{default: '0};
        else if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC/fetch stage with LUT-resolved branches, start/done handshake and cycle counter
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W = 10,
    parameter int LUT_DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             branch,
    input  logic             cond,
    input  logic [8:0]       imem_data,
    input  logic             lut_we,
    input  logic [3:0]       lut_waddr,
    input  logic [PC_W-1:0]  lut_wdata,
    output logic [PC_W-1:0]  imem_addr,
    output logic [8:0]       instr,
    output logic             instr_valid,
    output logic [PC_W-1:0]  pc,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);
    state_t state, state_n;
    logic [PC_W-1:0] pc_n, target;
    logic [CNT_W-1:0] cnt_n;
    logic running;
    assign running = state == RUN;
    assign instr = running ? imem_data : HALT_INSTR;
    assign instr_valid = running;
    assign done = state == DONE;
    assign imem_addr = pc;
    branch_lut #(.DEPTH(LUT_DEPTH), .W(PC_W)) u_lut (
        .clk(clk),
        .rst(reset),
        .we(lut_we),
        .waddr(lut_waddr),
        .wdata(lut_wdata),
        .raddr(instr[IDX_HI:IDX_LO]),
        .rdata(target)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            cycle_count <= cnt_n;
        end
    end
    // halt beats a taken branch, which beats end-of-memory, which beats increment
    always_comb begin
        state_n = state;
        pc_n = pc;
        cnt_n = cycle_count;
        if (running) begin
            cnt_n = &cycle_count ? cycle_count : cycle_count + 1'b1;
            if (instr == HALT_INSTR) state_n = DONE;
            else if (branch & cond) pc_n = target;
            else if (&pc) state_n = DONE;
            else pc_n = pc + 1'b1;
        end else if (start) begin
            state_n = RUN;
            pc_n = '0;
            cnt_n = '0;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a cycle-level reference model and literal spot checks
module tb_instr_fetch;
    localparam logic [8:0] HALT = 9'h1F0;
    logic clk = 0;
    logic reset, start, cond, force_br, lut_we;
    logic [3:0] lut_waddr;
    logic [9:0] lut_wdata, imem_addr, pc;
    logic [8:0] imem_data, instr;
    logic instr_valid, done, branch;
    logic [15:0] cycle_count;
    logic [8:0] imem [1024];
    int checks = 0, errors = 0;
    logic cmp_en = 0;
    int m_st;
    int m_pc, m_cnt;
    int m_lut [16];

    always #5 clk = ~clk;
    assign imem_data = imem[imem_addr];
    assign branch = force_br | (instr[8:6] == 3'b100);

    instr_fetch dut (
        .clk(clk), .reset(reset), .start(start), .branch(branch), .cond(cond),
        .imem_data(imem_data), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .imem_addr(imem_addr), .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .done(done), .cycle_count(cycle_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: m_st 0=idle 1=running 2=finished; driven by the program in imem, not by DUT outputs
    always @(posedge clk) begin
        if (reset) begin
            m_st <= 0; m_pc <= 0; m_cnt <= 0;
            for (int i = 0; i < 16; i++) m_lut[i] <= 0;
        end else begin
            if (m_st == 1) begin
                m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                if (imem[m_pc] == HALT) m_st <= 2;
                else if ((force_br || imem[m_pc][8:6] == 3'b100) && cond) m_pc <= m_lut[imem[m_pc][3:0]];
                else if (m_pc == 1023) m_st <= 2;
                else m_pc <= m_pc + 1;
            end else if (start) begin
                m_st <= 1; m_pc <= 0; m_cnt <= 0;
            end
            if (lut_we) m_lut[lut_waddr] <= int'(lut_wdata);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("done", done, m_st == 2);
            chk("instr_valid", instr_valid, m_st == 1);
            chk("instr", instr, (m_st == 1) ? imem[m_pc] : HALT);
            chk("cycle_count", cycle_count, m_cnt);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic lut_write(input int idx, input int val);
        lut_we = 1; lut_waddr = 4'(idx); lut_wdata = 10'(val); tick(); lut_we = 0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int n = 0;
        while (!done && n < maxc) begin tick(); n++; end
        chk(nm, done, 1'b1);
    endtask

    initial begin
        reset = 1; start = 0; cond = 0; force_br = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
        for (int i = 0; i < 1024; i++) imem[i] = 9'h000;
        tick(2);
        reset = 0; cmp_en = 1;
        chk("rst_pc", pc, 0); chk("rst_done", done, 0);
        chk("rst_cnt", cycle_count, 0); chk("rst_instr", instr, HALT);

        // straight-line program halting at address 5
        for (int i = 0; i < 5; i++) imem[i] = 9'(i);
        imem[5] = HALT;
        pulse_start();
        chk("t1_pc0", pc, 0);
        wait_done("t1_done", 20);
        chk("t1_pc", pc, 5); chk("t1_cnt", cycle_count, 6); chk("t1_valid", instr_valid, 0);

        // taken branch at pc 2 with same-cycle LUT overwrite, then not-taken
        lut_write(3, 10);
        imem[2] = 9'h103; imem[3] = HALT; imem[10] = HALT;
        cond = 1;
        pulse_start();
        chk("t2_done_fall", done, 0); chk("t2_restart_cnt", cycle_count, 0);
        tick(2);
        chk("t2_pc2", pc, 2);
        lut_we = 1; lut_waddr = 3; lut_wdata = 12;
        tick(); lut_we = 0;
        chk("t2_taken", pc, 10);
        wait_done("t2_done", 10);
        cond = 0;
        pulse_start(); tick(2);
        chk("t2n_pc2", pc, 2);
        tick();
        chk("t2n_not_taken", pc, 3);
        wait_done("t2n_done", 10);

        // tight loop on address 4
        lut_write(1, 4);
        imem[2] = 0; imem[3] = 0; imem[4] = 9'h101; imem[5] = HALT;
        cond = 1;
        pulse_start(); tick(4);
        chk("t3_pc_a", pc, 4); chk("t3_cnt_a", cycle_count, 4);
        tick();
        chk("t3_pc_b", pc, 4); chk("t3_cnt_b", cycle_count, 5);
        tick();
        chk("t3_pc_c", pc, 4); chk("t3_cnt_c", cycle_count, 6);
        tick();
        chk("t3_pc_d", pc, 4); chk("t3_cnt_d", cycle_count, 7);
        cond = 0;
        tick();
        chk("t3_pc_e", pc, 5); chk("t3_cnt_e", cycle_count, 8);
        wait_done("t3_done", 5);

        // start during RUN ignored; reset at pc 7 aborts
        for (int i = 0; i < 16; i++) imem[i] = 9'h000;
        imem[10] = HALT;
        pulse_start(); tick(2);
        pulse_start();
        chk("t5_start_ignored", pc, 3);
        tick(4);
        chk("t4_pc7", pc, 7);
        reset = 1; tick(); reset = 0;
        chk("t4_pc", pc, 0); chk("t4_done", done, 0);
        chk("t4_cnt", cycle_count, 0); chk("t4_valid", instr_valid, 0);
        imem[0] = 9'h103; imem[1] = 0; imem[2] = HALT;
        cond = 1;
        pulse_start();
        chk("t4_pc_at0", pc, 0);
        tick();
        chk("t4_lut_cleared", pc, 0);
        cond = 0;
        tick();
        chk("t4_pc1", pc, 1);
        wait_done("t4_done_end", 5);

        // run to the end of memory without wrapping
        for (int i = 0; i < 1024; i++) imem[i] = 9'h000;
        pulse_start();
        wait_done("t6_done", 1100);
        chk("t6_pc", pc, 1023); chk("t6_cnt", cycle_count, 1024);
        tick(2);
        chk("t6_hold", pc, 1023);

        // halt wins over a forced taken branch
        lut_write(0, 9);
        imem[0] = HALT;
        force_br = 1; cond = 1;
        pulse_start();
        tick();
        chk("t7_done", done, 1); chk("t7_pc", pc, 0); chk("t7_cnt", cycle_count, 1);
        force_br = 0; cond = 0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program-counter and fetch stage that sits directly upstream of the control decoder.
- Holds the PC and drives the instruction-memory address, presenting the 9-bit machine word to the decoder as instr.
- Resolves taken branches through a 16-entry branch-target LUT.
- Runs a start/done handshake with the testbench and counts executed cycles.

Parameters:
- PC_W, 10, PC and instruction-memory address width.
- LUT_DEPTH, 16, branch-target LUT entries; index taken from instr[3:0].
- HALT_INSTR, 9'h1F0, halt encoding (opcode 111, funct 11 is unused by the decoder).
- CNT_W, 16, cycle counter width.

Ports:
- clk, in, 1, system clock; all state updates on its rising edge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle pulse; begins or restarts program execution.
- branch, in, 1, Branch output of the control decoder for the current instr.
- cond, in, 1, branch condition from the datapath; taken = branch & cond.
- imem_data, in, 9, combinational instruction-memory read data at imem_addr.
- lut_we, in, 1, branch-LUT write enable.
- lut_waddr, in, 4, branch-LUT write index.
- lut_wdata, in, PC_W, branch-LUT write data (absolute target PC).
- imem_addr, out, PC_W, equals pc.
- instr, out, 9, instruction to the decoder.
- instr_valid, out, 1, high only while executing; downstream gates RegWrite/MemWrite with it.
- pc, out, PC_W, current PC.
- done, out, 1, high while in DONE.
- cycle_count, out, CNT_W, number of RUN cycles in the last/current run.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - Next edge sets state=IDLE, pc=0, done=0, cycle_count=0, all LUT entries=0.
  - Reset asserted mid-RUN aborts the run the same way; no partial state survives.
- States: IDLE, RUN, DONE.
- IDLE:
  - instr_valid=0; instr forced to HALT_INSTR; pc held at 0.
  - start=1 -> RUN next edge; pc=0, cycle_count=0.
- RUN:
  - instr = imem_data, combinational, zero latency from pc; instr_valid=1.
  - Each edge, priority order:
    1. instr==HALT_INSTR -> DONE; pc holds; branch is ignored.
    2. branch & cond -> pc = lut[instr[3:0]].
    3. pc == all-ones -> DONE; no wrap to 0.
    4. otherwise pc = pc+1.
  - cycle_count += 1 every RUN cycle, including the HALT cycle; saturates at all-ones.
  - start is ignored.
- DONE:
  - done=1; instr_valid=0; instr=HALT_INSTR; pc and cycle_count hold.
  - start=1 -> RUN next edge with pc=0 and cycle_count=0; done drops on that same edge.
- Branch LUT:
  - Synchronous write, asynchronous read.
  - Write and read of the same index in one cycle: the read returns the old value; the new value is visible next cycle.
  - Writes are accepted in every state, and a branch target of the current PC is legal (tight loop).
- Latency: a taken branch redirects with zero bubbles; instr at the new target appears the cycle after the branch.
- imem_addr == pc at all times.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - HALT_INSTR constant
  - OPC_BRANCH=3'b100
  - instruction field slice constants (opcode [8:6], LUT index [3:0]), which the decoder also uses.
- One sub-module, branch_lut: LUT_DEPTH x PC_W register file with one write port and one async read port, reset to 0.

Test Plan:
- Reset then start; imem holds 0x000..0x004 at addr 0-4 and HALT_INSTR at 5:
  - pc steps 0→5; done rises on the edge after pc=5.
  - cycle_count=6; instr_valid=0 in DONE.
- Write lut[3]=10; addr 2 holds a branch with index 3; branch=1, cond=1 at pc=2:
  - next pc=10, no intermediate value.
  - Repeat with cond=0: next pc=3.
- Tight loop with lut[1]=4 and a branch at addr 4; hold cond=1 for 3 cycles, then cond=0:
  - pc sequence 4,4,4,4,5.
  - cycle_count increments on every one of those cycles.
- Assert reset in RUN at pc=7:
  - next cycle pc=0, state IDLE, cycle_count=0, done=0, lut[3] reads 0.
- In DONE, pulse start:
  - done falls on that edge; pc=0; cycle_count restarts at 0.
  - A start pulse during RUN has no effect on pc.
- Fill imem with non-branch, non-halt words up to 1023:
  - pc reaches 1023, then DONE with pc=1023 held (no wrap).
  - Also: HALT_INSTR with branch=cond=1 enters DONE and does not branch.
